gs_mem_arbiter: RTL and testbench
=================================

Name: gs_mem_arbiter

Overview:
Shares one external 8-bit memory port (SRAM/SDRAM bridge) between the General Sound Z80 memory bus and a host-side loader port (ROM/sample upload, debug peek/poke). It stalls the GS core by gating its clock enable until each GS memory strobe has been serviced. It serves loader requests in the gaps, with round-robin fairness after every GS access. It sits between the GS core's MA/MDO/MDI/MRD_n/MWE_n pins and the board memory controller.

Parameters:
ACC_CYC, 2, clock cycles one memory access occupies (1..15); memory data sampled on the last cycle.
ADDR_W, 21, address width of the GS, loader and memory ports.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
CE_IN  in  1  base clock enable for the GS core
GS_CE  out  1  gated clock enable to the GS core
GS_MA  in  ADDR_W  GS memory address
GS_MDO  in  8  GS write data
GS_MRD_n  in  1  GS memory read strobe, active low
GS_MWE_n  in  1  GS memory write strobe, active low
GS_MDI  out  8  registered read data to the GS core
LD_HOLD  in  1  freeze the GS core (GS_CE forced 0) while high
LD_REQ  in  1  loader request, level
LD_WR  in  1  loader direction: 1 = write, 0 = read
LD_ADDR  in  ADDR_W  loader address
LD_DATA  in  8  loader write data
LD_ACK  out  1  one-cycle completion pulse
LD_Q  out  8  loader read data, valid while LD_ACK = 1
MEM_A  out  ADDR_W  memory address
MEM_D  out  8  memory write data
MEM_Q  in  8  memory read data
MEM_WE  out  1  memory write enable, active high
MEM_OE  out  1  memory output enable, active high

Behaviour:
- Reset values:
  - state IDLE; cnt 0.
  - MEM_A 0, MEM_D 0, MEM_WE 0, MEM_OE 0.
  - LD_ACK 0, LD_Q 0, GS_MDI 8'hFF.
  - gs_done 0, last_gs 0.
  - Reset mid-access aborts the access immediately: no ACK, no GS_MDI update.
- gs_strobe = ~GS_MRD_n | ~GS_MWE_n.
- gs_need = gs_strobe & ~gs_done.
- GS_CE = CE_IN & ~LD_HOLD & ~gs_need. This is combinational and is 0 during reset.
- gs_done:
  - set on the edge that completes a GS access;
  - cleared on any cycle where gs_strobe = 0.
  - Result: exactly one memory access per strobe assertion, however many T-states the strobe spans.
- States: IDLE, GS_ACC, LD_ACC.
- IDLE transitions:
  - If gs_need and LD_REQ are both set: GS wins when last_gs = 0; the loader wins when last_gs = 1.
  - If only one is set, that requester is served.
  - Entering GS_ACC: latch MEM_A = GS_MA, MEM_D = GS_MDO, MEM_WE = ~GS_MWE_n, MEM_OE = ~GS_MRD_n.
  - Entering LD_ACC: latch MEM_A = LD_ADDR, MEM_D = LD_DATA, MEM_WE = LD_WR, MEM_OE = ~LD_WR.
  - On entry to either access state: cnt = ACC_CYC-1; last_gs is updated to 1 (GS) or 0 (loader).
- GS_ACC / LD_ACC:
  - Memory outputs are held stable; cnt decrements each cycle.
  - When cnt = 0: sample MEM_Q (into GS_MDI on reads for GS, into LD_Q for the loader); drop MEM_WE and MEM_OE; return to IDLE.
  - On that same edge, set gs_done (GS access) or pulse LD_ACK for one cycle (loader access).
- Back-to-back: at least one IDLE cycle separates accesses, so MEM_WE/MEM_OE deassert for ≥1 cycle between accesses.
- Occupancy: each access occupies the bus for ACC_CYC cycles plus 1 IDLE cycle.
- Loader requests:
  - Must be held until LD_ACK.
  - LD_REQ still high on the cycle after ACK is treated as a new request.
  - LD_ADDR/LD_DATA/LD_WR are sampled only on entry to LD_ACC.
- LD_HOLD:
  - Does not block the access already in progress.
  - GS strobes still pending under LD_HOLD are serviced normally, because the core is frozen with its strobe held.
- GS_MDI keeps its last value between reads; GS writes never modify GS_MDI.
- Strobe deasserting while its GS access is in progress: the access completes anyway and gs_done clears the next cycle.

Test Plan:
- Reset, ACC_CYC=2, CE_IN=1, idle bus -> GS_CE=1, MEM_OE=MEM_WE=0, GS_MDI=FF, LD_ACK never pulses.
- GS read: GS_MRD_n=0, GS_MA=0x04010, MEM_Q=0x5A -> GS_CE=0 for 3 cycles; MEM_A=0x04010, MEM_OE high for exactly 2 cycles; GS_MDI=0x5A; GS_CE=1 while the strobe is held; no second MEM_OE pulse.
- GS write: GS_MWE_n=0, GS_MA=0x1C000, GS_MDO=0x33 -> one MEM_WE pulse, 2 cycles long, MEM_D=0x33; GS_MDI unchanged.
- Loader read: LD_REQ=1, LD_WR=0, LD_ADDR=0x00100, MEM_Q=0xC3 -> LD_ACK high for exactly 1 cycle with LD_Q=0xC3; GS_CE unaffected when there is no GS strobe.
- Contention: GS strobe and LD_REQ asserted together continuously, last_gs=0 -> order GS, loader, GS, loader; every access is separated by ≥1 IDLE cycle.
- LD_HOLD=1 with loader writes to 0x00000..0x0000F -> GS_CE=0 throughout; 16 MEM_WE pulses; 16 LD_ACKs; asserting RESET during the 5th access -> MEM_WE drops next cycle and no ACK is issued.

Source files
------------

// File: rtl/gs_mem_arbiter_if.sv
// Signal bundle between the GS core / host loader / memory controller and the arbiter.
// The arbiter uses the slave view; whatever drives the core, loader and memory uses master.
interface gs_mem_arbiter_if #(
    parameter int ADDR_W = 21
);
    logic              CE_IN;
    logic              GS_CE;
    logic [ADDR_W-1:0] GS_MA;
    logic [7:0]        GS_MDO;
    logic              GS_MRD_n;
    logic              GS_MWE_n;
    logic [7:0]        GS_MDI;
    logic              LD_HOLD;
    logic              LD_REQ;
    logic              LD_WR;
    logic [ADDR_W-1:0] LD_ADDR;
    logic [7:0]        LD_DATA;
    logic              LD_ACK;
    logic [7:0]        LD_Q;
    logic [ADDR_W-1:0] MEM_A;
    logic [7:0]        MEM_D;
    logic [7:0]        MEM_Q;
    logic              MEM_WE;
    logic              MEM_OE;

    modport slave (
        input  CE_IN, GS_MA, GS_MDO, GS_MRD_n, GS_MWE_n,
        input  LD_HOLD, LD_REQ, LD_WR, LD_ADDR, LD_DATA, MEM_Q,
        output GS_CE, GS_MDI, LD_ACK, LD_Q, MEM_A, MEM_D, MEM_WE, MEM_OE
    );

    modport master (
        output CE_IN, GS_MA, GS_MDO, GS_MRD_n, GS_MWE_n,
        output LD_HOLD, LD_REQ, LD_WR, LD_ADDR, LD_DATA, MEM_Q,
        input  GS_CE, GS_MDI, LD_ACK, LD_Q, MEM_A, MEM_D, MEM_WE, MEM_OE
    );
endinterface

// File: rtl/gs_mem_arbiter.sv
// Shares one 8-bit memory port between the GS Z80 bus and a host loader.
// The GS core is stalled through GS_CE until its strobe has been serviced once.
module gs_mem_arbiter #(
    parameter int ACC_CYC = 2,
    parameter int ADDR_W  = 21
) (
    input  logic              CLK,
    input  logic              RESET,
    gs_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GS_ACC = 2'd1,
        LD_ACC = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACC_CYC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_gs_done;
    logic              r_last_gs;
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_d;
    logic              r_mem_we;
    logic              r_mem_oe;
    logic              r_ld_ack;
    logic [7:0]        r_ld_q;
    logic [7:0]        r_gs_mdi;

    logic w_gs_strobe;
    logic w_gs_need;
    logic w_start_gs;
    logic w_start_ld;
    logic w_fin;

    assign w_gs_strobe = ~bus.GS_MRD_n | ~bus.GS_MWE_n;
    // gs_done masks a strobe that was already serviced but is still held by the core
    assign w_gs_need   = w_gs_strobe & ~r_gs_done;

    assign bus.GS_CE  = bus.CE_IN & ~bus.LD_HOLD & ~w_gs_need & ~RESET;
    assign bus.GS_MDI = r_gs_mdi;
    assign bus.LD_ACK = r_ld_ack;
    assign bus.LD_Q   = r_ld_q;
    assign bus.MEM_A  = r_mem_a;
    assign bus.MEM_D  = r_mem_d;
    assign bus.MEM_WE = r_mem_we;
    assign bus.MEM_OE = r_mem_oe;

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Round-robin: on a tie the requester not served last goes first
    always_comb begin
        w_state_nxt = r_state;
        w_start_gs  = 1'b0;
        w_start_ld  = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gs_need && (!bus.LD_REQ || !r_last_gs)) begin
                    w_start_gs  = 1'b1;
                    w_state_nxt = GS_ACC;
                end else if (bus.LD_REQ) begin
                    w_start_ld  = 1'b1;
                    w_state_nxt = LD_ACC;
                end
            end
            GS_ACC, LD_ACC: begin
                if (r_cnt == 4'd0) begin
                    w_fin       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt     <= 4'd0;
            r_gs_done <= 1'b0;
            r_last_gs <= 1'b0;
            r_mem_a   <= '0;
            r_mem_d   <= 8'h00;
            r_mem_we  <= 1'b0;
            r_mem_oe  <= 1'b0;
            r_ld_ack  <= 1'b0;
            r_ld_q    <= 8'h00;
            r_gs_mdi  <= 8'hFF;
        end else begin
            r_ld_ack <= 1'b0;
            if (w_start_gs) begin
                r_mem_a   <= bus.GS_MA;
                r_mem_d   <= bus.GS_MDO;
                r_mem_we  <= ~bus.GS_MWE_n;
                r_mem_oe  <= ~bus.GS_MRD_n;
                r_cnt     <= CNT_INIT;
                r_last_gs <= 1'b1;
            end else if (w_start_ld) begin
                r_mem_a   <= bus.LD_ADDR;
                r_mem_d   <= bus.LD_DATA;
                r_mem_we  <= bus.LD_WR;
                r_mem_oe  <= ~bus.LD_WR;
                r_cnt     <= CNT_INIT;
                r_last_gs <= 1'b0;
            end else if (w_fin) begin
                r_mem_we <= 1'b0;
                r_mem_oe <= 1'b0;
                if (r_state == GS_ACC) begin
                    if (r_mem_oe) r_gs_mdi <= bus.MEM_Q;
                end else begin
                    r_ld_q   <= bus.MEM_Q;
                    r_ld_ack <= 1'b1;
                end
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Completion wins so a strobe dropped mid-access still clears a cycle later
            if (w_fin && r_state == GS_ACC) r_gs_done <= 1'b1;
            else if (!w_gs_strobe)          r_gs_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gs_mem_arbiter.sv
// Directed and randomized bench for gs_mem_arbiter with a behavioural memory and a shadow model.
module tb_gs_mem_arbiter;
    localparam int ACC_CYC = 2;
    localparam int ADDR_W  = 21;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gs_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    gs_mem_arbiter #(.ACC_CYC(ACC_CYC), .ADDR_W(ADDR_W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory device: 512 bytes selected by MEM_A[8:0]; drives junk when not enabled
    logic [7:0] mem [512];
    logic [7:0] exp_mem [512];
    logic       pl_en;
    logic [8:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clk) begin
        if (pl_en)            mem[pl_addr] <= pl_data;
        else if (bus.MEM_WE)  mem[bus.MEM_A[8:0]] <= bus.MEM_D;
    end
    assign bus.MEM_Q = bus.MEM_OE ? mem[bus.MEM_A[8:0]] : 8'hEE;

    // Bus monitor: logs each access and checks its strobe length
    int acc_cnt = 0, we_cnt = 0, ack_cnt = 0, run_len = 0;
    logic prev_act = 1'b0, aborted = 1'b0;
    logic [ADDR_W-1:0] log_a [$];
    logic              log_we [$];
    logic [7:0]        log_d [$];

    always @(negedge clk) begin
        if (rst) aborted = 1'b1;
        if (bus.LD_ACK) ack_cnt++;
        if (bus.MEM_WE | bus.MEM_OE) begin
            if (!prev_act) begin
                acc_cnt++;
                if (bus.MEM_WE) we_cnt++;
                log_a.push_back(bus.MEM_A);
                log_we.push_back(bus.MEM_WE);
                log_d.push_back(bus.MEM_D);
                run_len = 1;
                aborted = rst;
            end else begin
                run_len++;
            end
        end else if (prev_act && !aborted) begin
            chk("acc_len", run_len, ACC_CYC);
        end
        prev_act = bus.MEM_WE | bus.MEM_OE;
    end

    task automatic ns(); @(negedge clk); #1; endtask
    task automatic ps(); @(posedge clk); #1; endtask

    task automatic wait_ce(output int lowc, output int ok);
        lowc = 0; ok = 0;
        for (int n = 0; n < 80; n++) begin
            ns();
            if (bus.GS_CE) begin ok = 1; break; end
            lowc++;
        end
    endtask

    task automatic wait_ack(output int hic, output int ok);
        hic = 0; ok = 0;
        for (int n = 0; n < 80; n++) begin
            ns();
            if (bus.GS_CE) hic++;
            if (bus.LD_ACK) begin ok = 1; break; end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, k0, w0, lowc, hic, ok, base, n, bad;
        logic gs_on;

        rst = 1'b1;
        bus.CE_IN = 1'b1; bus.GS_MA = '0; bus.GS_MDO = 8'h00;
        bus.GS_MRD_n = 1'b1; bus.GS_MWE_n = 1'b1; bus.LD_HOLD = 1'b0;
        bus.LD_REQ = 1'b0; bus.LD_WR = 1'b0; bus.LD_ADDR = '0; bus.LD_DATA = 8'h00;
        pl_en = 1'b1; pl_addr = 9'd0; pl_data = 8'h00;
        for (int i = 0; i < 512; i++) begin
            pl_addr = 9'(i);
            pl_data = (i == 256) ? 8'hC3 : (8'(i) ^ 8'h4A);
            exp_mem[i] = pl_data;
            ns();
        end
        pl_en = 1'b0;

        // reset state
        chk("rst_gs_ce", bus.GS_CE, 0);
        chk("rst_mem_we", bus.MEM_WE, 0);
        chk("rst_mem_oe", bus.MEM_OE, 0);
        chk("rst_mem_a", bus.MEM_A, 0);
        chk("rst_gs_mdi", bus.GS_MDI, 8'hFF);
        chk("rst_ld_ack", bus.LD_ACK, 0);
        ps(); rst = 1'b0;
        ns();
        chk("idle_gs_ce", bus.GS_CE, 1);
        chk("idle_gs_mdi", bus.GS_MDI, 8'hFF);
        k0 = ack_cnt; a0 = acc_cnt;
        repeat (5) ns();
        chk("idle_no_ack", ack_cnt - k0, 0);
        chk("idle_no_acc", acc_cnt - a0, 0);

        // GS read
        ps(); a0 = acc_cnt;
        bus.GS_MA = 21'h04010; bus.GS_MRD_n = 1'b0;
        wait_ce(lowc, ok);
        chk("gsrd_done", ok, 1);
        chk("gsrd_ce_low", lowc, ACC_CYC + 1);
        chk("gsrd_mdi", bus.GS_MDI, exp_mem[9'h010]);
        chk("gsrd_n_acc", acc_cnt - a0, 1);
        chk("gsrd_addr", log_a[$], 21'h04010);
        chk("gsrd_we", log_we[$], 0);
        bad = 0;
        repeat (4) begin ns(); if (!bus.GS_CE) bad++; end
        chk("gsrd_hold_ce", bad, 0);
        chk("gsrd_single", acc_cnt - a0, 1);
        ps(); bus.GS_MRD_n = 1'b1;

        // GS write
        ps(); w0 = we_cnt;
        bus.GS_MA = 21'h1C000; bus.GS_MDO = 8'h33; bus.GS_MWE_n = 1'b0;
        wait_ce(lowc, ok);
        chk("gswr_done", ok, 1);
        chk("gswr_n_we", we_cnt - w0, 1);
        chk("gswr_addr", log_a[$], 21'h1C000);
        chk("gswr_data", log_d[$], 8'h33);
        chk("gswr_mdi_keep", bus.GS_MDI, exp_mem[9'h010]);
        exp_mem[0] = 8'h33;
        ps(); bus.GS_MWE_n = 1'b1;

        // loader read
        ps(); k0 = ack_cnt;
        bus.LD_REQ = 1'b1; bus.LD_WR = 1'b0; bus.LD_ADDR = 21'h00100;
        wait_ack(hic, ok);
        chk("ldrd_done", ok, 1);
        chk("ldrd_q", bus.LD_Q, 8'hC3);
        bus.LD_REQ = 1'b0;
        ns();
        chk("ldrd_ack_1cyc", bus.LD_ACK, 0);
        chk("ldrd_ce", bus.GS_CE, 1);
        chk("ldrd_n_ack", ack_cnt - k0, 1);

        // contention: both held, expect GS, loader, GS, loader
        ps(); a0 = acc_cnt; k0 = ack_cnt; base = log_a.size();
        bus.GS_MA = 21'h00020; bus.GS_MRD_n = 1'b0;
        bus.LD_ADDR = 21'h00140; bus.LD_WR = 1'b0; bus.LD_REQ = 1'b1;
        gs_on = 1'b1; n = 0;
        while (acc_cnt - a0 < 4 && n < 80) begin
            ns(); n++;
            if (gs_on && bus.GS_CE) begin gs_on = 1'b0; bus.GS_MRD_n = 1'b1; end
            else if (!gs_on)        begin gs_on = 1'b1; bus.GS_MRD_n = 1'b0; end
        end
        bus.GS_MRD_n = 1'b1;
        n = 0;
        while (ack_cnt - k0 < 2 && n < 40) begin ns(); n++; end
        bus.LD_REQ = 1'b0;
        repeat (4) ns();
        chk("cont_n_acc", acc_cnt - a0, 4);
        chk("cont_n_ack", ack_cnt - k0, 2);
        if (log_a.size() >= base + 4) begin
            chk("cont_0_gs", log_a[base + 0], 21'h00020);
            chk("cont_1_ld", log_a[base + 1], 21'h00140);
            chk("cont_2_gs", log_a[base + 2], 21'h00020);
            chk("cont_3_ld", log_a[base + 3], 21'h00140);
        end else begin
            chk("cont_log_size", log_a.size() - base, 4);
        end

        // loader writes under LD_HOLD
        ps(); bus.LD_HOLD = 1'b1;
        ns();
        chk("hold_ce", bus.GS_CE, 0);
        w0 = we_cnt; k0 = ack_cnt; bad = 0;
        for (int i = 0; i < 16; i++) begin
            bus.LD_REQ = 1'b1; bus.LD_WR = 1'b1; bus.LD_ADDR = ADDR_W'(i);
            bus.LD_DATA = 8'($urandom);
            exp_mem[i] = bus.LD_DATA;
            wait_ack(hic, ok);
            bad += hic + (ok ? 0 : 1);
            bus.LD_REQ = 1'b0;
        end
        repeat (3) ns();
        chk("hold_n_we", we_cnt - w0, 16);
        chk("hold_n_ack", ack_cnt - k0, 16);
        chk("hold_ce_bad", bad, 0);

        // reset during the 5th loader write
        w0 = we_cnt; k0 = ack_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.LD_REQ = 1'b1; bus.LD_WR = 1'b1; bus.LD_ADDR = ADDR_W'(9'h0F0 + 9'(i));
            bus.LD_DATA = 8'($urandom);
            if (i < 4) begin
                exp_mem[9'h0F0 + i] = bus.LD_DATA;
                wait_ack(hic, ok);
                bus.LD_REQ = 1'b0;
            end else begin
                n = 0;
                while (!bus.MEM_WE && n < 40) begin ns(); n++; end
                chk("abort_started", bus.MEM_WE, 1);
                rst = 1'b1; k0 = ack_cnt;
                ns();
                chk("abort_we", bus.MEM_WE, 0);
                chk("abort_ce", bus.GS_CE, 0);
                ps(); rst = 1'b0; bus.LD_REQ = 1'b0; bus.LD_HOLD = 1'b0;
                repeat (3) ns();
                chk("abort_no_ack", ack_cnt - k0, 0);
                chk("abort_mdi", bus.GS_MDI, 8'hFF);
            end
        end
        chk("abort_n_we", we_cnt - w0, 5);

        // randomized concurrent GS and loader traffic against the shadow model
        fork
            begin
                int gidx, gok, glow;
                logic [ADDR_W-1:0] ga;
                for (int t = 0; t < 24; t++) begin
                    repeat ($urandom_range(0, 3)) ps();
                    ps();
                    gidx = $urandom_range(0, 127);
                    ga = ADDR_W'($urandom); ga[8:0] = 9'(gidx);
                    bus.GS_MA = ga;
                    if ($urandom_range(0, 1) == 1) begin
                        bus.GS_MDO = 8'($urandom); bus.GS_MWE_n = 1'b0;
                        wait_ce(glow, gok);
                        chk("rnd_gs_wr_done", gok, 1);
                        exp_mem[gidx] = bus.GS_MDO;
                    end else begin
                        bus.GS_MRD_n = 1'b0;
                        wait_ce(glow, gok);
                        chk("rnd_gs_rd_done", gok, 1);
                        chk("rnd_gs_rd", bus.GS_MDI, exp_mem[gidx]);
                    end
                    bus.GS_MRD_n = 1'b1; bus.GS_MWE_n = 1'b1;
                end
            end
            begin
                int lidx, lok, lhi;
                for (int t = 0; t < 24; t++) begin
                    repeat ($urandom_range(0, 3)) ps();
                    ps();
                    lidx = $urandom_range(256, 511);
                    bus.LD_ADDR = ADDR_W'(lidx);
                    bus.LD_WR = 1'($urandom_range(0, 1));
                    bus.LD_DATA = 8'($urandom);
                    bus.LD_REQ = 1'b1;
                    wait_ack(lhi, lok);
                    chk("rnd_ld_done", lok, 1);
                    if (bus.LD_WR) exp_mem[lidx] = bus.LD_DATA;
                    else           chk("rnd_ld_rd", bus.LD_Q, exp_mem[lidx]);
                    bus.LD_REQ = 1'b0;
                end
            end
        join
        repeat (4) ns();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
